// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm edit/arm/ring sequencer with auto-stop and optional snooze
// Optional feature macro: ALARM_SNOOZE_EN builds the SNOOZE state and snooze counter.
module alarm_ctrl #(
   parameter int unsigned RING_SECS  = 60,
   parameter int unsigned SNOOZE_MIN = 5
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic       tick_1s_i,
   input  logic       btn_set_i,
   input  logic       btn_inc_i,
   input  logic       btn_stop_i,
   input  logic       btn_snooze_i,
   input  logic [3:0] tim_d3_i,
   input  logic [3:0] tim_d2_i,
   input  logic [3:0] tim_d1_i,
   input  logic [3:0] tim_d0_i,
   input  logic [3:0] alm_d3_i,
   input  logic [3:0] alm_d2_i,
   input  logic [3:0] alm_d1_i,
   input  logic [3:0] alm_d0_i,
   output logic [3:0] set_d3_o,
   output logic [3:0] set_d2_o,
   output logic [3:0] set_d1_o,
   output logic [3:0] set_d0_o,
   output logic       ld_o,
   output logic       buzzer_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_EDIT_H = 3'd1,
      S_EDIT_M = 3'd2,
      S_ARMED  = 3'd3,
      S_RING   = 3'd4,
      S_SNOOZE = 3'd5
   } state_t;

   localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

   state_t     state_q, state_d;
   logic [3:0] hr_t_q, hr_t_d, hr_u_q, hr_u_d;
   logic [3:0] mn_t_q, mn_t_d, mn_u_q, mn_u_d;
   logic [3:0] hr_inc_t, hr_inc_u, mn_inc_t, mn_inc_u;
   logic       match, match_q, match_d;
   logic       ld_q, ld_d, ld_dly_q;
   logic       buzzer_q, buzzer_d;
   logic [7:0] ring_cnt_q, ring_cnt_d;
   logic       ring_done;
   logic       entering;

`ifdef ALARM_SNOOZE_EN
   localparam logic [11:0] SNZ_LAST = 12'(SNOOZE_MIN * 60 - 1);
   logic [11:0] snz_cnt_q, snz_cnt_d;
   logic        snz_done;
`else
   localparam int unsigned SNZ_TICKS_UNUSED = SNOOZE_MIN * 60;
   logic snooze_btn_unused;
   assign snooze_btn_unused = btn_snooze_i;
`endif

   assign match = (tim_d3_i == alm_d3_i) && (tim_d2_i == alm_d2_i) &&
                  (tim_d1_i == alm_d1_i) && (tim_d0_i == alm_d0_i);

   // BCD increment with 23:xx and xx:59 wrap to zero
   always_comb begin
      hr_inc_t = hr_t_q;
      hr_inc_u = hr_u_q + 4'd1;
      if (hr_t_q == 4'd2 && hr_u_q == 4'd3) begin
         hr_inc_t = 4'd0;
         hr_inc_u = 4'd0;
      end else if (hr_u_q == 4'd9) begin
         hr_inc_t = hr_t_q + 4'd1;
         hr_inc_u = 4'd0;
      end
      mn_inc_t = mn_t_q;
      mn_inc_u = mn_u_q + 4'd1;
      if (mn_t_q == 4'd5 && mn_u_q == 4'd9) begin
         mn_inc_t = 4'd0;
         mn_inc_u = 4'd0;
      end else if (mn_u_q == 4'd9) begin
         mn_inc_t = mn_t_q + 4'd1;
         mn_inc_u = 4'd0;
      end
   end

   always_comb begin
      state_d   = state_q;
      hr_t_d    = hr_t_q;
      hr_u_d    = hr_u_q;
      mn_t_d    = mn_t_q;
      mn_u_d    = mn_u_q;
      ring_done = tick_1s_i && (ring_cnt_q == RING_LAST);
`ifdef ALARM_SNOOZE_EN
      snz_done  = tick_1s_i && (snz_cnt_q == SNZ_LAST);
`endif
      case (state_q)
         S_IDLE: begin
            if (btn_set_i) state_d = S_EDIT_H;
         end
         S_EDIT_H: begin
            if (btn_stop_i)     state_d = S_IDLE;
            else if (btn_set_i) state_d = S_EDIT_M;
            else if (btn_inc_i) begin
               hr_t_d = hr_inc_t;
               hr_u_d = hr_inc_u;
            end
         end
         S_EDIT_M: begin
            if (btn_stop_i)     state_d = S_IDLE;
            else if (btn_set_i) state_d = S_ARMED;
            else if (btn_inc_i) begin
               mn_t_d = mn_inc_t;
               mn_u_d = mn_inc_u;
            end
         end
         S_ARMED: begin
            if (btn_stop_i)               state_d = S_IDLE;
            else if (match && !match_q)   state_d = S_RING;
            else if (btn_set_i)           state_d = S_EDIT_H;
         end
         S_RING: begin
            if (btn_stop_i)        state_d = S_ARMED;
`ifdef ALARM_SNOOZE_EN
            else if (btn_snooze_i) state_d = S_SNOOZE;
`endif
            else if (ring_done)    state_d = S_ARMED;
         end
`ifdef ALARM_SNOOZE_EN
         S_SNOOZE: begin
            if (btn_stop_i)    state_d = S_ARMED;
            else if (snz_done) state_d = S_RING;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      entering = (state_d != state_q);

      ring_cnt_d = ring_cnt_q;
      if (entering)                           ring_cnt_d = 8'd0;
      else if (state_q == S_RING && tick_1s_i) ring_cnt_d = ring_cnt_q + 8'd1;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_d = snz_cnt_q;
      if (entering)                             snz_cnt_d = 12'd0;
      else if (state_q == S_SNOOZE && tick_1s_i) snz_cnt_d = snz_cnt_q + 12'd1;
`endif

      // Storage output is zero during the first loaded cycle, so the edge detector is held off then too
      match_d = match;
      if (entering && state_d == S_ARMED)      match_d = 1'b1;
      else if (state_q == S_ARMED && !ld_dly_q) match_d = 1'b1;

      ld_d     = (state_d == S_ARMED) || (state_d == S_RING) || (state_d == S_SNOOZE);
      buzzer_d = (state_d == S_RING);
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q    <= S_IDLE;
         hr_t_q     <= 4'd0;
         hr_u_q     <= 4'd0;
         mn_t_q     <= 4'd0;
         mn_u_q     <= 4'd0;
         match_q    <= 1'b1;
         ld_q       <= 1'b0;
         ld_dly_q   <= 1'b0;
         buzzer_q   <= 1'b0;
         ring_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         hr_t_q     <= hr_t_d;
         hr_u_q     <= hr_u_d;
         mn_t_q     <= mn_t_d;
         mn_u_q     <= mn_u_d;
         match_q    <= match_d;
         ld_q       <= ld_d;
         ld_dly_q   <= ld_q;
         buzzer_q   <= buzzer_d;
         ring_cnt_q <= ring_cnt_d;
      end
   end

`ifdef ALARM_SNOOZE_EN
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) snz_cnt_q <= 12'd0;
      else         snz_cnt_q <= snz_cnt_d;
   end
`endif

   assign set_d3_o = hr_t_q;
   assign set_d2_o = hr_u_q;
   assign set_d1_o = mn_t_q;
   assign set_d0_o = mn_u_q;
   assign ld_o     = ld_q;
   assign buzzer_o = buzzer_q;
   assign state_o  = state_q;

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm sequencing controller for the digital clock. Lets the user edit the alarm time (HH:MM, 24 h, BCD) with set/increment buttons, drives the alarm storage register's digits and load level, compares the stored alarm against the running time, and controls the buzzer with auto-stop and optional snooze. Sits between the button front-end (debounced, single-cycle pulses) and the alarm storage register / buzzer driver.

## Interface
- RING_SECS, 60: seconds the buzzer sounds before auto-stop; legal 1..255.
- SNOOZE_MIN, 5: snooze length in minutes; legal 1..60.

- clk  in  1  system clock.
- reset_  in  1  asynchronous, active-low reset.
- tick_1s  in  1  one-cycle pulse per second, synchronous to clk.
- btn_set  in  1  one-cycle pulse: enter edit / advance edit field / commit.
- btn_inc  in  1  one-cycle pulse: increment the field being edited.
- btn_stop  in  1  one-cycle pulse: abort edit, disarm, or silence.
- btn_snooze  in  1  one-cycle pulse: snooze while ringing.
- tim_d3..tim_d0  in  4 each  current time BCD: hour tens, hour units, minute tens, minute units.
- alm_d3..alm_d0  in  4 each  alarm storage register outputs, same digit order.
- set_d3..set_d0  out  4 each  alarm digits to storage register.
- ld  out  1  storage register load level.
- buzzer  out  1  buzzer drive.
- state  out  3  FSM state code (debug).

## Operation
- Storage register reloads every clock; it clears to zero whenever ld is low. ld is therefore a level, high exactly in ARMED, RING, SNOOZE.
- States/codes: IDLE 0, EDIT_H 1, EDIT_M 2, ARMED 3, RING 4, SNOOZE 5.
- IDLE: ld=0, buzzer=0. btn_set -> EDIT_H.
- EDIT_H: btn_inc increments hours 00..23, 23 wraps to 00 (set_d3/set_d2 BCD). btn_set -> EDIT_M. btn_stop -> IDLE.
- EDIT_M: btn_inc increments minutes 00..59, 59 wraps to 00, hours untouched. btn_set -> ARMED. btn_stop -> IDLE.
- Edited digits persist across aborts and re-edits; only reset clears them.
- ARMED: match = (tim_d* == alm_d*) on all four digits. Ring on rising edge of match (match & ~match_q). On entry to ARMED match_q forced to 1, so the alarm never fires for the minute in which it was armed nor on the zeroed register output during the load cycle. btn_stop -> IDLE. btn_set -> EDIT_H (ld drops).
- RING: buzzer=1. ring counter counts tick_1s; after RING_SECS ticks -> ARMED. btn_stop -> ARMED (alarm remains armed for next day). btn_snooze -> SNOOZE (macro only).
- SNOOZE: buzzer=0; snooze counter counts tick_1s; after SNOOZE_MIN*60 ticks -> RING with ring counter cleared. btn_stop -> ARMED.
- btn_set and btn_inc ignored in RING and SNOOZE; btn_inc ignored outside edit states.
- Simultaneous events, priority: btn_stop > btn_snooze > counter expiry > btn_set > btn_inc.
- Counters: ring 8 bit, snooze 12 bit, both cleared on every state entry.

## Timing
- Reset: state IDLE, set_d* = 0, ld=0, buzzer=0, counters 0, match_q=1.
- All outputs registered; state change, ld, buzzer, set_d* update the cycle after the causing input pulse.
- Storage register output valid 1 cycle after ld rises; match comparison is edge-based, so that cycle is harmless.
- Ring latency: buzzer high 1 cycle after the cycle in which match first becomes true.
- Reset asserted mid-ring or mid-edit: immediate return to reset values; no ring resumes after release.

## Configuration
- ALARM_SNOOZE_EN defined: SNOOZE state, snooze counter and btn_snooze handling present.
- Undefined: btn_snooze ignored, SNOOZE unreachable, snooze counter not built; state code 5 never produced.

## Test plan
- Reset release -> state=0, ld=0, buzzer=0, set_d*=0000.
- set, inc x7, set, inc x30, set -> set_d*=0730, ld=1, state=3; time steps 07:29 -> 07:30 -> buzzer=1 one cycle later; 60 tick_1s later buzzer=0, state=3.
- Edit hours, inc x24 from 00 -> wraps to 00; minutes inc x60 -> wraps to 00; stop in EDIT_M -> state=0, digits retained.
- Arm at 07:30 while time is 07:30 -> no ring; time goes 07:31, next day 07:30 -> ring.
- Ringing, btn_snooze (macro on) -> buzzer=0, state=5; after 300 ticks -> buzzer=1; btn_stop and btn_snooze same cycle -> state=3.
- Reset pulse during RING -> buzzer=0, state=0, ld=0 immediately.
